alu_mul_sequencer: RTL and testbench

- Multi-cycle shift-add multiplier controller that computes the low REG_WIDTH bits of op_a*op_b (RV32M MUL semantics) by sequencing the shared single-cycle ALU.
- It uses only the ALU add operation (alu_control 4'b0010). Shifts of multiplicand and multiplier are done in local registers.
- It sits beside the main datapath and borrows the ALU through a req/gnt handshake, so the main datapath keeps priority.

---
 rtl/alu_mul_sequencer.sv | 71 +++++++
 tb/tb_alu_mul_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add multiplier (low REG_WIDTH bits of op_a*op_b)
// that borrows the shared ALU's add through a req/gnt handshake.
module alu_mul_sequencer #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] op_a,
  input  logic [REG_WIDTH-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] product,
  output logic                 alu_req,
  input  logic                 alu_gnt,
  output logic [3:0]           alu_control,
  output logic [REG_WIDTH-1:0] alu_in1,
  output logic [REG_WIDTH-1:0] alu_in2,
  input  logic [REG_WIDTH-1:0] alu_result
);
  localparam int CW = $clog2(REG_WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [REG_WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0] cnt;
  logic step, last;
  assign step = state == RUN && alu_gnt;
  // stop once no multiplier bits remain, or after the final bit position
  assign last = (mplier >> 1) == '0 || cnt == CW'(REG_WIDTH - 1);
  assign busy = state != IDLE;
  assign alu_req = state == RUN;
  assign alu_control = 4'b0010;
  assign alu_in1 = alu_req ? acc : '0;
  assign alu_in2 = alu_req && mplier[0] ? mcand : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = op_b != '0 ? RUN : DONE;
    if (step && last) state_nx = DONE;
    if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      product <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        acc <= '0;
        mcand <= op_a;
        mplier <= op_b;
        cnt <= '0;
      end
      if (step) begin
        acc <= alu_result;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
      end
      if (state == DONE) begin
        product <= acc;
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: random and directed multiplies checked against an
// arithmetic model of partial products, grant-driven latency and the done pulse.
module tb_alu_mul_sequencer;
  logic clk = 1'b0, reset, start, busy, done, alu_req, alu_gnt;
  logic [31:0] op_a, op_b, product, alu_in1, alu_in2, alu_result;
  logic [3:0] alu_control;
  logic [31:0] last_prod;
  int n_tests = 0, n_fail = 0;

  alu_mul_sequencer #(.REG_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .alu_req(alu_req),
    .alu_gnt(alu_gnt), .alu_control(alu_control), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_result(alu_result)
  );

  always #5 clk = ~clk;
  // shared ALU: sums when granted, otherwise busy with someone else's work
  assign alu_result = alu_gnt ? alu_in1 + alu_in2 : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"}, {31'd0, alu_req}, 32'd0);
    chk({tag, "_in1"}, alu_in1, 32'd0);
    chk({tag, "_in2"}, alu_in2, 32'd0);
    chk({tag, "_ctrl"}, {28'd0, alu_control}, 32'd2);
  endtask

  // stall[k]=1 withholds the grant on the k-th cycle after start; rnd adds random stalls
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] stall, input bit rnd);
    int n, g, k;
    bit gnt;
    logic [31:0] mask, exp_in2;
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    chk("prod_hold", product, last_prod);
    op_a = a;
    op_b = b;
    start = 1'b1;
    alu_gnt = 1'b1;
    @(posedge clk); #1;
    g = 0;
    k = 0;
    while (g < n) begin
      mask = (32'h1 << g) - 32'h1;
      exp_in2 = b[g] ? a << g : 32'd0;
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_req", {31'd0, alu_req}, 32'd1);
      chk("run_done", {31'd0, done}, 32'd0);
      chk("run_in1", alu_in1, a * (b & mask));
      chk("run_in2", alu_in2, exp_in2);
      chk("run_ctrl", {28'd0, alu_control}, 32'd2);
      gnt = !(k < 64 && stall[k]) && (!rnd || $urandom_range(0, 3) != 0);
      alu_gnt = gnt;
      start = 1'($urandom_range(0, 1));
      op_a = $urandom;
      op_b = $urandom;
      if (gnt) g++;
      k++;
      @(posedge clk); #1;
    end
    chk("dst_busy", {31'd0, busy}, 32'd1);
    chk("dst_done", {31'd0, done}, 32'd0);
    chk("dst_prod", product, last_prod);
    chk_quiet("dst");
    alu_gnt = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("product", product, a * b);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk_quiet("idle");
    last_prod = a * b;
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    alu_gnt = 1'b1;
    op_a = '0;
    op_b = '0;
    last_prod = '0;
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_prod", product, 32'd0);
    chk_quiet("rst");
    reset = 1'b0;
    // abort mid-RUN
    op_a = 32'd9;
    op_b = 32'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_prod", product, 32'd0);
    chk_quiet("abort");
    #2 reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_abort_done", {31'd0, done}, 32'd0);
      chk("post_abort_busy", {31'd0, busy}, 32'd0);
    end
    run_mul(32'd7, 32'd6, 64'd0, 1'b0);
    run_mul(32'hFFFF_FFFD, 32'd5, 64'd0, 1'b0);
    run_mul(32'd1, 32'h8000_0000, 64'd0, 1'b0);
    run_mul(32'h1234, 32'd0, 64'd0, 1'b0);
    run_mul(32'd7, 32'd6, 64'h6, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b1);
    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run_mul(ra, rb, 64'd0, 1'b1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
